ld_updn_counter: RTL and testbench

LD_UPDN_COUNTER -- requirements
Module: ld_updn_counter

---
 rtl/ld_updn_counter.sv | 72 +++++++
 tb/tb_ld_updn_counter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ld_updn_counter.sv
// Loadable up/down counter with programmable terminal count, wrap or saturate
// at the boundaries, combinational cascade carry and a sticky overflow flag.
module ld_updn_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INIT  = '0,
  parameter string            MODE  = "WRAP"
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             SP,
  input  logic             LOAD,
  input  logic             CI,
  input  logic             UP,
  input  logic             CLR_OVF,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF
);

  localparam bit SAT = (MODE == "SAT");

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;
  logic             w_up_edge;
  logic             w_dn_edge;
  logic             w_boundary;

  // One extra bit keeps MAXV = 2**WIDTH-1 from aliasing to zero on increment.
  assign w_inc     = {1'b0, r_q} + {{WIDTH{1'b0}}, 1'b1};
  assign w_dec     = {1'b0, r_q} - {{WIDTH{1'b0}}, 1'b1};
  assign w_up_edge = (w_inc > {1'b0, MAXV});
  assign w_dn_edge = w_dec[WIDTH];

  assign CO         = CI & ((UP & w_up_edge) | (~UP & w_dn_edge));
  assign w_boundary = SP & ~LOAD & CO;

  always_comb begin
    w_q_nxt = r_q;
    if (LOAD) begin
      w_q_nxt = (D > MAXV) ? MAXV : D;
    end else if (CI) begin
      if (UP) begin
        if (w_up_edge) w_q_nxt = SAT ? MAXV : '0;
        else           w_q_nxt = w_inc[WIDTH-1:0];
      end else begin
        if (w_dn_edge) w_q_nxt = SAT ? '0 : MAXV;
        else           w_q_nxt = w_dec[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_q   <= INIT;
      r_ovf <= 1'b0;
    end else if (SP) begin
      r_q <= w_q_nxt;
      // Set wins over a simultaneous clear.
      if (w_boundary)   r_ovf <= 1'b1;
      else if (CLR_OVF) r_ovf <= 1'b0;
    end
  end

  assign Q   = r_q;
  assign OVF = r_ovf;

endmodule

// File: tb/tb_ld_updn_counter.sv
// Self-checking bench for ld_updn_counter: directed vector table, randomized
// run against an arithmetic reference model, and directed multi-cycle cases.
module tb_ld_updn_counter;

  typedef struct {
    logic       sp, ld, ci, up, clr;
    logic [3:0] d;
    logic [3:0] eq;
    logic       eco, eovf;
  } vec_t;

  logic       CK, RSTN, SP, LOAD, CI, UP, CLR_OVF;
  logic [3:0] D;
  logic [3:0] q_w   [4];
  logic       co_w  [4];
  logic       ovf_w [4];

  logic       c_sp, c_ld, c_ci, c_up, c_clr;
  logic [3:0] c_d;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_ovf, hi_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state/parameters for instances 0..3.
  int m_q [4];
  int m_ovf [4];
  int m_max [4]  = '{9, 9, 15, 9};
  int m_sat [4]  = '{0, 1, 0, 0};
  int m_init [4] = '{0, 0, 0, 5};

  vec_t vec[$];

  ld_updn_counter #(.WIDTH(4), .MAXV(4'd9), .INIT(4'd0), .MODE("WRAP")) u_wrap (
    .CK(CK), .RSTN(RSTN), .SP(SP), .LOAD(LOAD), .CI(CI), .UP(UP), .CLR_OVF(CLR_OVF),
    .D(D), .Q(q_w[0]), .CO(co_w[0]), .OVF(ovf_w[0]));
  ld_updn_counter #(.WIDTH(4), .MAXV(4'd9), .INIT(4'd0), .MODE("SAT")) u_sat (
    .CK(CK), .RSTN(RSTN), .SP(SP), .LOAD(LOAD), .CI(CI), .UP(UP), .CLR_OVF(CLR_OVF),
    .D(D), .Q(q_w[1]), .CO(co_w[1]), .OVF(ovf_w[1]));
  ld_updn_counter #(.WIDTH(4)) u_full (
    .CK(CK), .RSTN(RSTN), .SP(SP), .LOAD(LOAD), .CI(CI), .UP(UP), .CLR_OVF(CLR_OVF),
    .D(D), .Q(q_w[2]), .CO(co_w[2]), .OVF(ovf_w[2]));
  ld_updn_counter #(.WIDTH(4), .MAXV(4'd9), .INIT(4'd5), .MODE("WRAP")) u_i5 (
    .CK(CK), .RSTN(RSTN), .SP(SP), .LOAD(LOAD), .CI(CI), .UP(UP), .CLR_OVF(CLR_OVF),
    .D(D), .Q(q_w[3]), .CO(co_w[3]), .OVF(ovf_w[3]));

  ld_updn_counter #(.WIDTH(4), .MAXV(4'd9)) u_lo (
    .CK(CK), .RSTN(RSTN), .SP(c_sp), .LOAD(c_ld), .CI(c_ci), .UP(c_up), .CLR_OVF(c_clr),
    .D(c_d), .Q(lo_q), .CO(lo_co), .OVF(lo_ovf));
  ld_updn_counter #(.WIDTH(4), .MAXV(4'd9)) u_hi (
    .CK(CK), .RSTN(RSTN), .SP(c_sp), .LOAD(c_ld), .CI(lo_co), .UP(c_up), .CLR_OVF(c_clr),
    .D(c_d), .Q(hi_q), .CO(hi_co), .OVF(hi_ovf));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic sp, ld, ci, up, clr, input logic [3:0] d);
    SP = sp; LOAD = ld; CI = ci; UP = up; CLR_OVF = clr; D = d;
  endtask

  task automatic add_vec(input logic sp, ld, ci, up, clr, input logic [3:0] d,
                         input logic [3:0] eq, input logic eco, eovf);
    vec_t v;
    v.sp = sp; v.ld = ld; v.ci = ci; v.up = up; v.clr = clr; v.d = d;
    v.eq = eq; v.eco = eco; v.eovf = eovf;
    vec.push_back(v);
  endtask

  // Spec rules in plain arithmetic: modulo for wrap, clamp for saturate.
  function automatic int exp_co(int i, logic ci, logic up);
    return (ci && (up ? (m_q[i] == m_max[i]) : (m_q[i] == 0))) ? 1 : 0;
  endfunction

  task automatic model_step(input int i);
    int bnd;
    bnd = (SP && !LOAD) ? exp_co(i, CI, UP) : 0;
    if (SP) begin
      if (LOAD) m_q[i] = (int'(D) > m_max[i]) ? m_max[i] : int'(D);
      else if (CI) begin
        if (m_sat[i] != 0)
          m_q[i] = UP ? ((m_q[i] + 1 > m_max[i]) ? m_max[i] : m_q[i] + 1)
                      : ((m_q[i] - 1 < 0) ? 0 : m_q[i] - 1);
        else
          m_q[i] = UP ? (m_q[i] + 1) % (m_max[i] + 1)
                      : (m_q[i] + m_max[i]) % (m_max[i] + 1);
      end
      if (bnd != 0)    m_ovf[i] = 1;
      else if (CLR_OVF) m_ovf[i] = 0;
    end
  endtask

  // Reset held across an active edge with count enabled, then released mid-cycle.
  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    RSTN = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_q%0d", i), q_w[i], m_init[i]);
      chk($sformatf("rst_ovf%0d", i), ovf_w[i], 0);
    end
    chk("rst_co_wrap", co_w[0], 1);
    chk("rst_co_i5", co_w[3], 0);
    @(posedge CK); #1;
    chk("rst_hold_q_i5", q_w[3], 5);
    chk("rst_hold_q_wrap", q_w[0], 0);
    #2 RSTN = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      m_q[i] = m_init[i];
      m_ovf[i] = 0;
    end
  endtask

  initial begin
    int k;
    RSTN = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    c_sp = 1'b1; c_ld = 1'b0; c_ci = 1'b0; c_up = 1'b1; c_clr = 1'b0; c_d = 4'd0;
    #2;
    do_reset();

    // Directed table on u_wrap (MAXV=9, WRAP).
    for (int n = 1; n <= 12; n++)
      add_vec(1, 0, 1, 1, 0, 4'd0, 4'(n % 10), (n % 10) == 9, n >= 10);
    add_vec(1, 1, 1, 1, 0, 4'hC, 4'd9, 1, 1);
    add_vec(1, 1, 1, 1, 0, 4'd3, 4'd3, 0, 1);
    add_vec(1, 1, 0, 1, 0, 4'd0, 4'd0, 0, 1);
    add_vec(0, 1, 1, 0, 1, 4'd5, 4'd0, 1, 1);
    add_vec(0, 1, 0, 0, 1, 4'd5, 4'd0, 0, 1);
    add_vec(0, 1, 1, 1, 1, 4'd5, 4'd0, 0, 1);
    add_vec(1, 0, 0, 0, 1, 4'd0, 4'd0, 0, 0);
    add_vec(1, 0, 1, 0, 0, 4'd0, 4'd9, 0, 1);
    add_vec(1, 0, 1, 0, 1, 4'd0, 4'd8, 0, 0);
    add_vec(1, 1, 0, 0, 0, 4'd0, 4'd0, 0, 0);
    add_vec(1, 0, 1, 0, 1, 4'd0, 4'd9, 0, 1);
    add_vec(1, 0, 1, 1, 0, 4'd0, 4'd0, 0, 1);
    foreach (vec[n]) begin
      drive(vec[n].sp, vec[n].ld, vec[n].ci, vec[n].up, vec[n].clr, vec[n].d);
      @(posedge CK); #1;
      chk($sformatf("vec%0d_q", n), q_w[0], vec[n].eq);
      chk($sformatf("vec%0d_co", n), co_w[0], vec[n].eco);
      chk($sformatf("vec%0d_ovf", n), ovf_w[0], vec[n].eovf);
    end

    // Randomized run against the reference model on all four instances.
    #1 do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 4) != 0,
            1'($urandom), ($urandom % 8) == 0, 4'($urandom));
      for (int i = 0; i < 4; i++) model_step(i);
      @(posedge CK); #1;
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("rnd%0d_q%0d", n, i), q_w[i], m_q[i]);
        chk($sformatf("rnd%0d_ovf%0d", n, i), ovf_w[i], m_ovf[i]);
        chk($sformatf("rnd%0d_co%0d", n, i), co_w[i], exp_co(i, CI, UP));
      end
    end

    // Saturating count-down from 2, then clear OVF with CI=0.
    drive(1, 1, 0, 0, 1, 4'd2);
    @(posedge CK); #1;
    chk("sat_load_q", q_w[1], 2);
    chk("sat_load_ovf", ovf_w[1], 0);
    for (int n = 1; n <= 4; n++) begin
      drive(1, 0, 1, 0, 0, 4'd0);
      @(posedge CK); #1;
      chk($sformatf("sat_dn%0d_q", n), q_w[1], (n == 1) ? 1 : 0);
      chk($sformatf("sat_dn%0d_co", n), co_w[1], (n >= 2) ? 1 : 0);
      chk($sformatf("sat_dn%0d_ovf", n), ovf_w[1], (n >= 3) ? 1 : 0);
    end
    drive(1, 0, 0, 0, 1, 4'd0);
    @(posedge CK); #1;
    chk("sat_clr_ovf", ovf_w[1], 0);
    chk("sat_clr_q", q_w[1], 0);

    // Asynchronous reset between edges at Q=7 on the INIT=5 instance.
    drive(1, 1, 0, 1, 0, 4'd7);
    @(posedge CK); #1;
    chk("ar_load_q", q_w[3], 7);
    drive(1, 0, 1, 1, 0, 4'd0);
    #2 RSTN = 1'b0;
    #1;
    chk("ar_q_init", q_w[3], 5);
    chk("ar_ovf", ovf_w[3], 0);
    #2 RSTN = 1'b1;
    for (int n = 6; n <= 8; n++) begin
      @(posedge CK); #1;
      chk($sformatf("ar_resume_%0d", n), q_w[3], n);
      chk($sformatf("ar_resume_ovf_%0d", n), ovf_w[3], 0);
    end

    // Two-digit cascade counting 00..99 and back to 00.
    #1 RSTN = 1'b0;
    #2 RSTN = 1'b1;
    c_ci = 1'b1;
    k = 0;
    for (int n = 1; n <= 101; n++) begin
      @(posedge CK); #1;
      k = n % 100;
      chk($sformatf("cas%0d_lo", n), lo_q, k % 10);
      chk($sformatf("cas%0d_hi", n), hi_q, k / 10);
      chk($sformatf("cas%0d_loco", n), lo_co, (k % 10) == 9);
      chk($sformatf("cas%0d_hiovf", n), hi_ovf, n >= 100);
    end
    chk("cas_lo_ovf", lo_ovf, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
